// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encoding, type-field location, the
// end-of-packet test and the output-port arbiter state encoding.
package noc_pkg;

  // Flit type carried in the two most significant bits of every flit.
  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  // Type-field bit positions counted down from the flit's top bit, so the
  // field is flit[W-1-FLIT_TYPE_MSB : W-1-FLIT_TYPE_LSB] for any width W.
  localparam int FLIT_TYPE_MSB = 0;
  localparam int FLIT_TYPE_LSB = 1;

  // Output-port ownership state.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // True for the flit that closes a packet (TAIL or SINGLE).
  function automatic logic is_last(input logic [1:0] ftype);
    return (ftype == FLIT_TAIL) || (ftype == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// searching upward from ptr, wrapping modulo N (N need not be a power of two).
module rr_arbiter #(
  parameter int N = 5,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  // Scan N positions starting at ptr; the first asserted request wins.
  always_comb begin
    logic [PTR_W:0] idx;
    logic           found;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (idx >= (PTR_W + 1)'(N)) begin
        idx = idx - (PTR_W + 1)'(N);
      end
      if (!found && req[idx[PTR_W-1:0]]) begin
        gnt[idx[PTR_W-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Wormhole output-port arbiter: round-robin packet arbitration, grant locked
// until the tail flit leaves, FIFO read sequencing (1-cycle read latency) and
// credit-based flow control toward the downstream buffer.
// Optional stall watchdog: define OUTPUT_PORT_ARBITER_WATCHDOG_EN to add the
// sticky stall_err output.
module output_port_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_IN          = 5,
  parameter int DATA_WIDTH      = 18,
  parameter int CREDITS         = 64,
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            req,
  input  logic [NUM_IN-1:0]            fifo_empty,
  output logic [NUM_IN-1:0]            fifo_rd_en,
  input  logic [NUM_IN*DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                         credit_in,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [NUM_IN-1:0]            grant,
  output logic                         busy
`ifdef OUTPUT_PORT_ARBITER_WATCHDOG_EN
  ,
  output logic                         stall_err
`endif
);

  localparam int PTR_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int CRED_W = $clog2(CREDITS + 1);

  arb_state_e          state_reg, state_next;
  logic [NUM_IN-1:0]   grant_reg, grant_next;
  logic [PTR_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic                rd_pending_reg;
  logic [CRED_W-1:0]   credits_reg, credits_next;

  logic [NUM_IN-1:0]   arb_gnt;
  logic [PTR_W-1:0]    grant_idx;
  logic [DATA_WIDTH-1:0] data_slice [NUM_IN];
  logic [DATA_WIDTH-1:0] data_mux;
  logic                out_last;
  logic                release_pkt;
  logic                grant_empty;
  logic                can_read;
  logic                rd_any;

  rr_arbiter #(.N(NUM_IN)) u_rr_arbiter (
    .req (req),
    .ptr (rr_ptr_reg),
    .gnt (arb_gnt)
  );

  // Zero every FIFO slice except the granted one so the OR below is a mux.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_slice
      assign data_slice[gi] = grant_reg[gi] ? fifo_rd_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  endgenerate

  // Combine the masked slices; yields zero when nothing is granted.
  always_comb begin
    data_mux = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      data_mux = data_mux | data_slice[k];
    end
  end

  // Binary index of the current owner, used for the pointer update.
  always_comb begin
    grant_idx = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (grant_reg[k]) begin
        grant_idx = PTR_W'(k);
      end
    end
  end

  assign out_data    = data_mux;
  assign out_valid   = rd_pending_reg;
  assign grant       = grant_reg;
  assign busy        = (state_reg == LOCKED);
  assign out_last    = is_last(data_mux[DATA_WIDTH-1-FLIT_TYPE_MSB : DATA_WIDTH-1-FLIT_TYPE_LSB]);
  assign release_pkt = (state_reg == LOCKED) && rd_pending_reg && out_last;
  assign grant_empty = |(fifo_empty & grant_reg);

  // Read the owner's FIFO while data and credit exist, never past a tail in flight.
  assign can_read   = (state_reg == LOCKED) && !grant_empty && (credits_reg != '0) &&
                      (!rd_pending_reg || !out_last);
  assign fifo_rd_en = can_read ? grant_reg : '0;
  assign rd_any     = |fifo_rd_en;

  // Next-state logic: arbitrate in IDLE, hold the grant until the tail leaves.
  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    rr_ptr_next = rr_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next = LOCKED;
          grant_next = arb_gnt;
        end
      end
      LOCKED: begin
        if (release_pkt) begin
          state_next  = IDLE;
          grant_next  = '0;
          rr_ptr_next = (grant_idx == PTR_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  // Credit bookkeeping: a read consumes, a returned credit refunds, saturating at full.
  always_comb begin
    credits_next = credits_reg;
    case ({rd_any, credit_in})
      2'b10:   credits_next = credits_reg - 1'b1;
      2'b01:   if (credits_reg != CRED_W'(CREDITS)) credits_next = credits_reg + 1'b1;
      default: credits_next = credits_reg;
    endcase
  end

  // State, ownership, pointer, read-tracking and credit registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      rr_ptr_reg     <= '0;
      rd_pending_reg <= 1'b0;
      credits_reg    <= CRED_W'(CREDITS);
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      rr_ptr_reg     <= rr_ptr_next;
      rd_pending_reg <= rd_any;
      credits_reg    <= credits_next;
    end
  end

`ifdef OUTPUT_PORT_ARBITER_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_reg;
  logic            stall_err_reg;
  logic            wd_stalled;

  assign wd_stalled = (state_reg == LOCKED) && !rd_pending_reg;
  assign stall_err  = stall_err_reg;

  // Count consecutive locked cycles with no output; flag sticky once the limit is hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_reg    <= '0;
      stall_err_reg <= 1'b0;
    end else begin
      if (wd_stalled) begin
        if (wd_cnt_reg != WD_W'(WATCHDOG_CYCLES)) begin
          wd_cnt_reg <= wd_cnt_reg + 1'b1;
        end
        if (wd_cnt_reg == WD_W'(WATCHDOG_CYCLES - 1)) begin
          stall_err_reg <= 1'b1;
        end
      end else begin
        wd_cnt_reg <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// Randomized bench for output_port_arbiter: bench-side FIFOs with 1-cycle
// registered read, random packet/credit traffic, and a packet-level reference
// model (owner, round-robin pointer, credit count, flit in flight).
module tb_output_port_arbiter;

  localparam int N  = 5;
  localparam int DW = 18;
  localparam int CR = 4;
  localparam int WD = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    fifo_empty;
  logic [N-1:0]    fifo_rd_en;
  logic [N*DW-1:0] fifo_rd_data;
  logic            credit_in;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [N-1:0]    grant;
  logic            busy;
`ifdef OUTPUT_PORT_ARBITER_WATCHDOG_EN
  logic            stall_err;
`endif

  always #5 clk = ~clk;

  output_port_arbiter #(
    .NUM_IN(N), .DATA_WIDTH(DW), .CREDITS(CR), .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .credit_in    (credit_in),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .grant        (grant),
    .busy         (busy)
`ifdef OUTPUT_PORT_ARBITER_WATCHDOG_EN
    ,
    .stall_err    (stall_err)
`endif
  );

  // Bench FIFOs, flits not yet pushed, and registered FIFO read outputs.
  logic [DW-1:0] fifo_q [N][$];
  logic [DW-1:0] src_q  [N][$];
  logic [DW-1:0] rd_reg [N];
  int unsigned   seq    [N];

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int            m_owner;
  int            m_ptr;
  int            m_credits;
  bit            m_pend;
  bit            m_tail_sent;
  logic [DW-1:0] m_pend_flit;
  int            m_pkts = 0;
  int            dut_pkts = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit flit_last(input logic [DW-1:0] f);
    return (f[DW-1:DW-2] == 2'b10) || (f[DW-1:DW-2] == 2'b11);
  endfunction

  function automatic bit flit_starts(input logic [DW-1:0] f);
    return (f[DW-1:DW-2] == 2'b01) || (f[DW-1:DW-2] == 2'b11);
  endfunction

  function automatic int rr_winner(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic gen_packet(input int i);
    int            len;
    logic [1:0]    t;
    logic [15:0]   payload;
    logic [3:0]    id;
    len = $urandom_range(1, 4);
    id  = 4'(i);
    for (int k = 0; k < len; k++) begin
      if (len == 1)           t = 2'b11;
      else if (k == 0)        t = 2'b01;
      else if (k == len - 1)  t = 2'b10;
      else                    t = 2'b00;
      payload = {id, 12'(seq[i])};
      seq[i]++;
      src_q[i].push_back({t, payload});
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = (fifo_q[i].size() == 0);
      req[i]        = (fifo_q[i].size() != 0) && flit_starts(fifo_q[i][0]);
      fifo_rd_data[i*DW +: DW] = rd_reg[i];
    end
  endtask

  task automatic model_reset();
    m_owner     = -1;
    m_ptr       = 0;
    m_credits   = CR;
    m_pend      = 1'b0;
    m_tail_sent = 1'b0;
    m_pend_flit = '0;
  endtask

  // One clock cycle: check outputs, advance the model, then update the FIFOs.
  task automatic step(input int p_push, input int p_credit);
    logic [31:0]  exp_grant;
    logic [31:0]  exp_rd;
    logic [N-1:0] dut_rd;
    bit           rd;
    bit           next_pend;
    @(negedge clk);
    exp_grant = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
    chk("grant", 32'(grant), exp_grant);
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("out_valid", 32'(out_valid), 32'(m_pend));
    if (m_pend) chk("out_data", 32'(out_data), 32'(m_pend_flit));
    exp_rd = (m_owner >= 0 && fifo_q[m_owner].size() > 0 && m_credits > 0 && !m_tail_sent)
             ? (32'd1 << m_owner) : 32'd0;
    chk("rd_en", 32'(fifo_rd_en), exp_rd);
    if (out_valid && flit_last(out_data)) dut_pkts++;

    rd = (exp_rd != 0);
    if (rd && !credit_in) m_credits--;
    else if (!rd && credit_in && m_credits < CR) m_credits++;
    next_pend = 1'b0;
    if (m_owner < 0) begin
      if (req != '0) m_owner = rr_winner(req, m_ptr);
    end else if (m_pend && flit_last(m_pend_flit)) begin
      m_ptr       = (m_owner + 1) % N;
      m_owner     = -1;
      m_tail_sent = 1'b0;
      m_pkts++;
    end else if (rd) begin
      m_pend_flit = fifo_q[m_owner][0];
      next_pend   = 1'b1;
      if (flit_last(m_pend_flit)) m_tail_sent = 1'b1;
    end
    m_pend = next_pend;
    dut_rd = fifo_rd_en;

    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (dut_rd[i] && fifo_q[i].size() > 0) rd_reg[i] = fifo_q[i].pop_front();
      if (src_q[i].size() == 0 && $urandom_range(0, 99) < 30) gen_packet(i);
      if (src_q[i].size() > 0 && $urandom_range(0, 99) < p_push)
        fifo_q[i].push_back(src_q[i].pop_front());
    end
    credit_in = ($urandom_range(0, 99) < p_credit);
    drive_inputs();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
`ifdef OUTPUT_PORT_ARBITER_WATCHDOG_EN
    chk({tag, "_stall_err"}, 32'(stall_err), 32'd0);
`endif
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < N; i++) begin
      fifo_q[i].delete();
      src_q[i].delete();
      rd_reg[i] = '0;
    end
  endtask

  initial begin
    bit found;
    rst          = 1'b1;
    credit_in    = 1'b0;
    req          = '0;
    fifo_empty   = '1;
    fifo_rd_data = '0;
    for (int i = 0; i < N; i++) begin
      rd_reg[i] = '0;
      seq[i]    = 0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    drive_inputs();

    // Phase 1: mixed traffic with frequent credit starvation and FIFO underflow.
    for (int c = 0; c < 1500; c++) step(60, 35);

    // Find a cycle with a non-final flit on the output, then reset mid-packet.
    found = 1'b0;
    for (int t = 0; t < 400 && !found; t++) begin
      if (m_owner >= 0 && m_pend && !flit_last(m_pend_flit)) found = 1'b1;
      else step(60, 35);
    end
    chk("midpkt_found", 32'(found), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midpkt_rst");
    credit_in = 1'b0;
    clear_fifos();
    model_reset();
    drive_inputs();
    @(negedge clk);
    rst = 1'b0;

    // Phase 2: recovery after reset, heavier load and faster credit return.
    for (int c = 0; c < 1500; c++) step(85, 60);

    chk("pkt_count", 32'(dut_pkts), 32'(m_pkts));
    chk("progress", 32'(m_pkts > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
